// File: rtl/chi_lite_dir_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chi_lite_dir_ctrl : one-transaction-at-a-time coherence directory controller
// Rev 1.0
// ---------------------------------------------------------------------------
module chi_lite_dir_ctrl #(
  parameter int NREQ  = 4,
  parameter int LINES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [32*NREQ-1:0]  req_index,
  output logic                dir_rd_en,
  output logic                dir_wr_en,
  output logic [31:0]         dir_index,
  output logic [7:0]          dir_state_wr,
  output logic [63:0]         dir_sharers_wr,
  input  logic [7:0]          dir_state_rd,
  input  logic [63:0]         dir_sharers_rd,
  output logic                snp_valid,
  input  logic                snp_ready,
  output logic [63:0]         snp_mask,
  output logic [31:0]         snp_index,
  input  logic                snp_ack,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [5:0]          rsp_id,
  output logic [7:0]          rsp_state,
  output logic                rsp_err,
  output logic                busy,
  output logic                err_ack
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_SNOOP, ST_WAIT_ACK, ST_UPDATE, ST_RESP
  } state_t;

  localparam logic [1:0] DIR_I = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] OP_RS = 2'd0;
  localparam logic [1:0] OP_RU = 2'd1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_t      state_q, state_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  gid_q, gid_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] idx_q, idx_d;
  logic [1:0]  dst_q, dst_d;
  logic [63:0] dsh_q, dsh_d;
  logic [63:0] victim_q, victim_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  rsp_state_q, rsp_state_d;
  logic        err_ack_q, err_ack_d;

  logic        gnt_found;
  logic [5:0]  gnt_id;
  logic [5:0]  ptr_nxt;
  logic        oob;
  logic [1:0]  rd_st;
  logic [63:0] bit_g;
  logic [63:0] victim_lk;
  logic [6:0]  pop;
  logic [1:0]  new_st;
  logic [63:0] new_sh;

  // Round-robin search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_id    = 6'(j);
      end
    end
    ptr_nxt = (int'(gnt_id) + 1 >= NREQ) ? 6'd0 : gnt_id + 6'd1;
  end

  assign oob   = (idx_q >= 32'(LINES));
  assign rd_st = (dir_state_rd > 8'd2) ? DIR_U : dir_state_rd[1:0];
  assign bit_g = 64'd1 << gid_q;

  always_comb begin
    victim_lk = '0;
    case (op_q)
      OP_RS:   victim_lk = (rd_st == DIR_U) ? (dir_sharers_rd & ~bit_g) : 64'd0;
      OP_RU:   victim_lk = dir_sharers_rd & ~bit_g;
      default: victim_lk = '0;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < 64; k++) pop = pop + 7'(victim_q[k]);
  end

  always_comb begin
    new_st = DIR_I;
    new_sh = '0;
    case (op_q)
      OP_RS: begin
        new_st = DIR_S;
        new_sh = (dsh_q & ~victim_q) | bit_g;
      end
      OP_RU: begin
        new_st = DIR_U;
        new_sh = bit_g;
      end
      default: begin
        new_sh = dsh_q & ~bit_g;
        new_st = (new_sh == 64'd0) ? DIR_I : dst_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    op_d        = op_q;
    idx_d       = idx_q;
    dst_d       = dst_q;
    dsh_d       = dsh_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rsp_state_d = rsp_state_q;
    // Any ack that is not consuming an outstanding count is a protocol error.
    err_ack_d   = err_ack_q | (snp_ack & ~((state_q == ST_WAIT_ACK) && (cnt_q != 7'd0)));
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          gid_d   = gnt_id;
          op_d    = req_op[2*gnt_id +: 2];
          idx_d   = req_index[32*gnt_id +: 32];
          ptr_d   = ptr_nxt;
          err_d   = 1'b0;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (oob) begin
          err_d       = 1'b1;
          rsp_state_d = 8'd0;
          state_d     = ST_RESP;
        end else begin
          dst_d    = rd_st;
          dsh_d    = dir_sharers_rd;
          victim_d = victim_lk;
          state_d  = (victim_lk != 64'd0) ? ST_SNOOP : ST_UPDATE;
        end
      end
      ST_SNOOP: begin
        if (snp_ready) begin
          cnt_d   = pop;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (snp_ack && (cnt_q != 7'd0)) begin
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        rsp_state_d = {6'd0, new_st};
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      dst_q       <= '0;
      dsh_q       <= '0;
      victim_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_state_q <= '0;
      err_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      dst_q       <= dst_d;
      dsh_q       <= dsh_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_state_q <= rsp_state_d;
      err_ack_q   <= err_ack_d;
    end
  end

  // The grant is a same-cycle handshake, so it is masked while reset is held.
  assign req_ready      = (rst_n && (state_q == ST_IDLE) && gnt_found) ? (ONE_HOT0 << gnt_id) : '0;
  assign dir_rd_en      = (state_q == ST_LOOKUP) && !oob;
  assign dir_wr_en      = (state_q == ST_UPDATE);
  assign dir_index      = (dir_rd_en || dir_wr_en) ? idx_q : 32'd0;
  assign dir_state_wr   = dir_wr_en ? {6'd0, new_st} : 8'd0;
  assign dir_sharers_wr = dir_wr_en ? new_sh : 64'd0;
  assign snp_valid      = (state_q == ST_SNOOP);
  assign snp_mask       = snp_valid ? victim_q : 64'd0;
  assign snp_index      = snp_valid ? idx_q : 32'd0;
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_id         = rsp_valid ? gid_q : 6'd0;
  assign rsp_state      = rsp_valid ? rsp_state_q : 8'd0;
  assign rsp_err        = rsp_valid & err_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_ack        = err_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_chi_lite_dir_ctrl.sv
`default_nettype none
// tb_chi_lite_dir_ctrl : directed and randomized transactions checked against a
// transaction-level directory model (round-robin grant, victim mask, update rules).
module tb_chi_lite_dir_ctrl;
  localparam int NREQ  = 4;
  localparam int LINES = 1024;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [32*NREQ-1:0]  req_index;
  logic                dir_rd_en, dir_wr_en;
  logic [31:0]         dir_index;
  logic [7:0]          dir_state_wr, dir_state_rd;
  logic [63:0]         dir_sharers_wr, dir_sharers_rd;
  logic                snp_valid, snp_ready, snp_ack;
  logic [63:0]         snp_mask;
  logic [31:0]         snp_index;
  logic                rsp_valid, rsp_ready, rsp_err;
  logic [5:0]          rsp_id;
  logic [7:0]          rsp_state;
  logic                busy, err_ack;

  always #5 clk = ~clk;

  chi_lite_dir_ctrl #(.NREQ(NREQ), .LINES(LINES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_index(req_index),
    .dir_rd_en(dir_rd_en), .dir_wr_en(dir_wr_en), .dir_index(dir_index),
    .dir_state_wr(dir_state_wr), .dir_sharers_wr(dir_sharers_wr),
    .dir_state_rd(dir_state_rd), .dir_sharers_rd(dir_sharers_rd),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_mask(snp_mask), .snp_index(snp_index),
    .snp_ack(snp_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_state(rsp_state),
    .rsp_err(rsp_err), .busy(busy), .err_ack(err_ack)
  );

  // Backing store the DUT reads/writes, and the model's own view of the directory.
  logic [7:0]  mem_st [LINES];
  logic [63:0] mem_sh [LINES];
  int          ref_st [LINES];
  logic [63:0] ref_sh [LINES];

  always_comb begin
    dir_state_rd   = 8'd0;
    dir_sharers_rd = 64'd0;
    if (dir_index < LINES) begin
      dir_state_rd   = mem_st[dir_index[9:0]];
      dir_sharers_rd = mem_sh[dir_index[9:0]];
    end
  end

  int ntests = 0;
  int nfail  = 0;
  int m_ptr  = 0;
  bit m_err  = 1'b0;
  int cnt_rd = 0;
  int cnt_wr = 0;
  int          t_op  [NREQ];
  logic [31:0] t_idx [NREQ];
  int          obs_g, obs_wst, obs_rst, obs_id;
  logic [63:0] obs_wsh, obs_mask;
  logic        obs_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("rd_wr_exclusive", 64'(dir_rd_en & dir_wr_en), 64'd0);
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      chk("err_ack", 64'(err_ack), 64'(m_err));
      if (dir_rd_en) cnt_rd++;
      if (dir_wr_en) cnt_wr++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]    = 2'(t_op[i]);
      req_index[32*i +: 32] = t_idx[i];
    end
  endtask

  task automatic set_line(input int l, input int s, input logic [63:0] sh);
    ref_st[l] = s;
    ref_sh[l] = sh;
    mem_st[l] = 8'(s);
    mem_sh[l] = sh;
  endtask

  task automatic idle_cycle(input bit stray);
    @(negedge clk);
    req_valid = '0; snp_ready = 1'b0; rsp_ready = 1'b0; snp_ack = stray;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    if (stray) m_err = 1'b1;
  endtask

  task automatic run_txn(input logic [NREQ-1:0] vld, input int hold_snp, input int gap_max,
                         input int hold_rsp, input bit rst_mid);
    int g, op, st, nst, n, gap;
    logic [31:0] idx;
    logic [63:0] sh, bitg, vic, nsh;
    bit oob;
    @(negedge clk);
    snp_ready = 1'b0; snp_ack = 1'b0; rsp_ready = 1'b0;
    req_valid = vld;
    drive_req();
    #1;
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      int j = (m_ptr + i) % NREQ;
      if (g < 0 && vld[j]) g = j;
    end
    chk("grant", 64'(req_ready), 64'(1) << g);
    chk("accept_busy", 64'(busy), 64'd0);
    m_ptr = (g + 1) % NREQ;
    obs_g = g;
    op  = t_op[g];
    idx = t_idx[g];
    oob = (idx >= LINES);
    bitg = 64'(1) << g;
    st = 0; sh = '0; vic = '0; nst = 0; nsh = '0;
    if (!oob) begin
      st = (ref_st[idx[9:0]] > 2) ? 2 : ref_st[idx[9:0]];
      sh = ref_sh[idx[9:0]];
      if (op == 0) begin
        vic = (st == 2) ? (sh & ~bitg) : 64'd0;
        nst = 1;
        nsh = (sh & ~vic) | bitg;
      end else if (op == 1) begin
        vic = sh & ~bitg;
        nst = 2;
        nsh = bitg;
      end else begin
        nsh = sh & ~bitg;
        nst = (nsh == 64'd0) ? 0 : st;
      end
    end

    @(negedge clk); #1;
    chk("busy_ready", 64'(req_ready), 64'd0);
    chk("lookup_busy", 64'(busy), 64'd1);
    chk("lookup_rd_en", 64'(dir_rd_en), 64'(!oob));
    if (!oob) chk("lookup_index", 64'(dir_index), 64'(idx));

    if (!oob && vic != 64'd0) begin
      for (int k = 0; k <= hold_snp; k++) begin
        @(negedge clk);
        snp_ready = (k == hold_snp);
        #1;
        chk("snp_valid", 64'(snp_valid), 64'd1);
        chk("snp_mask", snp_mask, vic);
        chk("snp_index", 64'(snp_index), 64'(idx));
        chk("snp_no_wr", 64'(dir_wr_en), 64'd0);
        obs_mask = snp_mask;
      end
      n = $countones(vic);
      for (int a = 0; a < n; a++) begin
        gap = $urandom_range(0, gap_max);
        for (int k = 0; k < gap; k++) begin
          @(negedge clk);
          snp_ready = 1'b0; snp_ack = 1'b0;
          #1;
          chk("wait_no_wr", 64'(dir_wr_en), 64'd0);
          chk("wait_no_snp", 64'(snp_valid), 64'd0);
        end
        @(negedge clk);
        snp_ready = 1'b0;
        if (rst_mid && a == 1) begin
          snp_ack = 1'b0; rst_n = 1'b0; req_valid = '0;
          m_err = 1'b0; m_ptr = 0;
          #1;
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_rd_wr", 64'({dir_rd_en, dir_wr_en}), 64'd0);
          chk("rst_valids", 64'({snp_valid, rsp_valid, rsp_err}), 64'd0);
          chk("rst_ready", 64'(req_ready), 64'd0);
          chk("rst_data", 64'({dir_index, rsp_state, rsp_id}) | snp_mask, 64'd0);
          repeat (2) begin
            @(negedge clk); #1;
            chk("rst_hold_wr", 64'(dir_wr_en), 64'd0);
          end
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        snp_ack = 1'b1;
        #1;
        chk("ack_no_wr", 64'(dir_wr_en), 64'd0);
      end
    end

    if (!oob) begin
      @(negedge clk);
      snp_ack = 1'b0; snp_ready = 1'b0;
      #1;
      chk("upd_wr_en", 64'(dir_wr_en), 64'd1);
      chk("upd_rd_en", 64'(dir_rd_en), 64'd0);
      chk("upd_index", 64'(dir_index), 64'(idx));
      chk("upd_state", 64'(dir_state_wr), 64'(nst));
      chk("upd_sharers", dir_sharers_wr, nsh);
      obs_wst = int'(dir_state_wr);
      obs_wsh = dir_sharers_wr;
      mem_st[idx[9:0]] = dir_state_wr;
      mem_sh[idx[9:0]] = dir_sharers_wr;
    end

    for (int k = 0; k <= hold_rsp; k++) begin
      @(negedge clk);
      rsp_ready = (k == hold_rsp);
      #1;
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(g));
      chk("rsp_state", 64'(rsp_state), oob ? 64'd0 : 64'(nst));
      chk("rsp_err", 64'(rsp_err), 64'(oob));
      chk("rsp_no_dir", 64'({dir_rd_en, dir_wr_en}), 64'd0);
      chk("rsp_ready_held", 64'(req_ready), 64'd0);
      obs_rst = int'(rsp_state);
      obs_err = rsp_err;
      obs_id  = int'(rsp_id);
    end
    if (!oob) begin
      ref_st[idx[9:0]] = nst;
      ref_sh[idx[9:0]] = nsh;
    end
  endtask

  initial begin
    int cr, cw;
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_index = '0;
    snp_ready = 1'b0; snp_ack = 1'b0; rsp_ready = 1'b0;
    for (int l = 0; l < LINES; l++) set_line(l, int'($urandom_range(0, 4)), 64'($urandom_range(0, 15)));
    for (int i = 0; i < NREQ; i++) begin t_op[i] = 0; t_idx[i] = 32'(20 + i); end

    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_strobes", 64'({dir_rd_en, dir_wr_en, snp_valid, rsp_valid, rsp_err, err_ack}), 64'd0);
    chk("reset_data", 64'({dir_index, rsp_state, rsp_id}) | snp_mask | dir_sharers_wr, 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesters held valid: grants rotate 0,1,2,3,0.
    for (int r = 0; r < 5; r++) begin
      run_txn(4'hF, 0, 0, 0, 1'b0);
      chk("rr_sequence", 64'(obs_g), 64'(r % 4));
    end

    set_line(5, 0, 64'h0);
    t_op[1] = 0; t_idx[1] = 32'd5;
    run_txn(4'b0010, 0, 0, 0, 1'b0);
    chk("rs_lit_state", 64'(obs_wst), 64'd1);
    chk("rs_lit_sharers", obs_wsh, 64'h2);
    chk("rs_lit_rsp", 64'({obs_id, obs_rst}), 64'({32'd1, 32'd1}));

    set_line(5, 1, 64'hB);
    t_op[2] = 1; t_idx[2] = 32'd5;
    run_txn(4'b0100, 1, 1, 1, 1'b0);
    chk("ru_lit_mask", obs_mask, 64'hB);
    chk("ru_lit_state", 64'(obs_wst), 64'd2);
    chk("ru_lit_sharers", obs_wsh, 64'h4);
    chk("ru_lit_rsp", 64'(obs_rst), 64'd2);

    t_op[0] = 0; t_idx[0] = 32'd1024;
    cr = cnt_rd; cw = cnt_wr;
    run_txn(4'b0001, 0, 0, 0, 1'b0);
    chk("oob_lit_err", 64'(obs_err), 64'd1);
    chk("oob_lit_state", 64'(obs_rst), 64'd0);
    chk("oob_lit_no_dir", 64'((cnt_rd - cr) + (cnt_wr - cw)), 64'd0);

    set_line(7, 2, 64'h1);
    t_op[0] = 2; t_idx[0] = 32'd7;
    run_txn(4'b0001, 0, 0, 0, 1'b0);
    chk("ev_lit_state", 64'(obs_wst), 64'd0);
    chk("ev_lit_sharers", obs_wsh, 64'h0);
    idle_cycle(1'b1);
    @(negedge clk);
    snp_ack = 1'b0;
    #1;
    chk("stray_lit_err_ack", 64'(err_ack), 64'd1);

    set_line(9, 1, 64'h7);
    t_op[3] = 1; t_idx[3] = 32'd9;
    run_txn(4'b1000, 0, 1, 0, 1'b1);
    chk("rst_lit_err_ack", 64'(err_ack), 64'd0);
    t_op[0] = 0; t_idx[0] = 32'd9;
    run_txn(4'b0001, 0, 0, 0, 1'b0);
    chk("post_rst_lit_state", 64'(obs_wst), 64'd1);
    chk("post_rst_lit_sharers", obs_wsh, 64'h7);
    chk("post_rst_lit_id", 64'(obs_id), 64'd0);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 9) == 0) idle_cycle($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        t_op[i]  = int'($urandom_range(0, 3));
        t_idx[i] = ($urandom_range(0, 9) == 0) ? 32'(LINES + int'($urandom_range(0, 3)))
                                                : 32'($urandom_range(0, 15));
      end
      run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)), 2,
              int'($urandom_range(0, 2)), $urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/chi_lite_dir_ctrl.md
CHI_LITE_DIR_CTRL -- requirements
Module: chi_lite_dir_ctrl

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (1..64); requester i owns sharer bit i.
REQ-002 Parameter LINES, default 1024, directory depth.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  one-hot grant/accept.
REQ-007 req_op  input  2*NREQ  per-requester opcode: 0 ReadShared, 1 ReadUnique, 2 Evict, 3 reserved (treated as Evict).
REQ-008 req_index  input  32*NREQ  per-requester line index.
REQ-009 dir_rd_en, dir_wr_en  output  1 each  directory read/write strobes.
REQ-010 dir_index  output  32  directory index.
REQ-011 dir_state_wr  output  8; dir_sharers_wr  output  64  write data.
REQ-012 dir_state_rd  input  8; dir_sharers_rd  input  64  combinational read data for dir_index.
REQ-013 snp_valid  output  1; snp_ready  input  1; snp_mask  output  64; snp_index  output  32  invalidate snoop.
REQ-014 snp_ack  input  1  one pulse per invalidated sharer.
REQ-015 rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  6; rsp_state  output  8; rsp_err  output  1.
REQ-016 busy  output  1  FSM not in IDLE; err_ack  output  1  sticky unexpected-ack flag.

Function
REQ-017 Directory state encoding SHALL be 0 I, 1 S, 2 U; other values read SHALL be treated as U.
REQ-018 FSM states SHALL be IDLE, LOOKUP, SNOOP, WAIT_ACK, UPDATE, RESP.
REQ-019 IDLE: if any req_valid, round-robin grant starting at ptr, assert req_ready[g] for that cycle only, capture op/index/g, set ptr=(g+1) mod NREQ, go LOOKUP.
REQ-020 LOOKUP: if index>=LINES go RESP with rsp_err=1 and no directory access; else assert dir_rd_en with dir_index=captured index for one cycle and register dir_state_rd/dir_sharers_rd.
REQ-021 Victim mask: ReadUnique = sharers & ~bit(g); ReadShared = sharers & ~bit(g) only if state U, else 0; Evict = 0.
REQ-022 LOOKUP -> SNOOP if victim mask non-zero, else -> UPDATE.
REQ-023 SNOOP: hold snp_valid=1, snp_mask=victim, snp_index stable until snp_ready; on handshake load ack counter (7 bits) = popcount(victim), go WAIT_ACK.
REQ-024 WAIT_ACK: decrement counter per snp_ack cycle; go UPDATE the cycle the counter reaches 0.
REQ-025 snp_ack outside WAIT_ACK, or with counter 0, SHALL be ignored and set err_ack until reset.
REQ-026 UPDATE: dir_wr_en=1 one cycle, dir_index=captured index; ReadShared -> S, (sharers & ~victim)|bit(g); ReadUnique -> U, bit(g); Evict -> sharers & ~bit(g), state I if result 0 else old state.
REQ-027 RESP: rsp_valid=1, rsp_id=g, rsp_state=written state (0 for rsp_err), held until rsp_ready; then IDLE.
REQ-028 dir_wr_en and dir_rd_en SHALL never be high in the same cycle; only one transaction in flight.
REQ-029 Latency without snoop, rsp_ready=1: accept cycle N, dir_rd_en N+1, dir_wr_en N+2, rsp_valid N+3, next accept N+4 earliest.
REQ-030 req_valid withdrawn before grant SHALL be legal; ungranted requesters SHALL see req_ready=0.

Reset
REQ-031 On rst_n low: FSM IDLE, ptr=0, counter=0, err_ack=0, every valid/strobe/ready output 0, all data outputs 0.
REQ-032 Reset mid-transaction SHALL abandon it without any dir_wr_en pulse.

Verification
REQ-033 Line 5 state I, req 1 ReadShared idx 5 -> dir write S, sharers 0x2, rsp_id 1, rsp_state 1 at cycle N+3.
REQ-034 Line 5 S sharers 0xB, req 2 ReadUnique -> snp_mask 0xB, three acks, write U sharers 0x4, rsp_state 2.
REQ-035 All four req_valid held continuously -> grants 0,1,2,3,0 in order.
REQ-036 Req idx 1024 with LINES=1024 -> rsp_err 1, no dir_rd_en/dir_wr_en.
REQ-037 Line 7 U sharers 0x1, req 0 Evict -> write I sharers 0; stray snp_ack in IDLE -> err_ack 1.
REQ-038 rst_n low during WAIT_ACK -> outputs 0, no write, next request served normally.
